// File: rtl/signed_acc_with_overflow_pkg.sv
// Shared helpers for the signed frame accumulator: signed range limits and counter sizing.
// Pure constant functions, no logic of their own.
package signed_acc_pkg;

    function automatic logic signed [31:0] smax(input int width);
        return (32'sd1 <<< (width - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] smin(input int width);
        return -(32'sd1 <<< (width - 1));
    endfunction

    // A single-term frame still needs a one-bit counter to keep the register legal.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/signed_acc_with_overflow_if.sv
// Sample in / frame result out bundle for the signed frame accumulator.
// Valid-only on both sides: the producer never stalls and the consumer must take every pulse.
// Master drives samples and observes results; slave is the accumulator.
interface signed_acc_with_overflow_if #(
    parameter int WIDTH = 4
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_data;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_sum;
    logic                    out_overflow;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_sum, out_overflow
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_sum, out_overflow
    );
endinterface

// File: rtl/signed_acc_with_overflow_add_ovf.sv
// Signed WIDTH-bit adder with sign-rule overflow detect; clamps when SIGNED_ACC_SATURATE_EN is defined.
// Latency: combinational.
// Backpressure: none.
module signed_add_ovf
    import signed_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    overflow
);
    logic signed [WIDTH-1:0] raw;

    assign raw      = a + b;
    // Only like-signed operands can overflow, and then the result sign flips.
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);

`ifdef SIGNED_ACC_SATURATE_EN
    localparam logic signed [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));
    localparam logic signed [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));

    always_comb begin
        sum = raw;
        if (overflow) begin
            sum = a[WIDTH-1] ? SMIN : SMAX;
        end
    end
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/signed_acc_with_overflow.sv
// Sums frames of N_TERMS signed samples; sticky per-frame overflow (clamping if SIGNED_ACC_SATURATE_EN).
// Latency: out_valid pulses one cycle after the edge accepting the final sample of a frame.
// Backpressure: none; every valid sample is consumed, one per cycle, frames back-to-back.
module signed_acc_with_overflow
    import signed_acc_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int N_TERMS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    signed_acc_with_overflow_if.slave  bus
);
    localparam int              CW   = cnt_w(N_TERMS);
    localparam logic [CW-1:0]   LAST = CW'(N_TERMS - 1);

    logic signed [WIDTH-1:0] acc;
    logic [CW-1:0]           cnt;
    logic                    ovf_acc;
    logic signed [WIDTH-1:0] step_sum;
    logic                    step_ovf;
    logic                    out_valid_q;
    logic signed [WIDTH-1:0] out_sum_q;
    logic                    out_overflow_q;

    signed_add_ovf #(.WIDTH(WIDTH)) u_add (
        .a        (acc),
        .b        (bus.in_data),
        .sum      (step_sum),
        .overflow (step_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc            <= '0;
            cnt            <= '0;
            ovf_acc        <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
                if (cnt == LAST) begin
                    // Publish and restart in the same edge so the next sample opens a new frame.
                    out_sum_q      <= step_sum;
                    out_overflow_q <= ovf_acc | step_ovf;
                    out_valid_q    <= 1'b1;
                    acc            <= '0;
                    ovf_acc        <= 1'b0;
                    cnt            <= '0;
                end else begin
                    acc     <= step_sum;
                    ovf_acc <= ovf_acc | step_ovf;
                    cnt     <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = out_sum_q;
    assign bus.out_overflow = out_overflow_q;

endmodule

// File: doc/signed_acc_with_overflow.md
# signed_acc_with_overflow

Parametrised, registered successor to the 4-bit combinational signed adder. It sums frames of `N_TERMS` consecutive two's-complement samples of `WIDTH` bits. Overflow is detected at every addition step, and each completed frame is presented with a one-cycle valid pulse and a sticky frame-level overflow flag. It sits in the arithmetics/pipelining section as the reusable signed accumulation stage for downstream filter and averaging blocks.

## Interface
- `WIDTH`, 4, data width of samples, running sum and result (≥ 2)
- `N_TERMS`, 4, samples per frame (≥ 1)

- `clk`  input  1  clock, all state on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `in_valid`  input  1  sample present this cycle; no backpressure, every valid sample is consumed
- `in_data`  input  WIDTH  signed sample
- `out_valid`  output  1  one-cycle pulse, frame result valid
- `out_sum`  output  WIDTH  signed frame sum, held until next frame completes
- `out_overflow`  output  1  any step of the frame overflowed, held with `out_sum`

## Operation
- Internal state: running sum `acc` (WIDTH, signed), sample counter `cnt` (`$clog2(N_TERMS)` bits, minimum 1), sticky flag `ovf_acc`.
- Step rule for each accepted sample: `next = acc + in_data`, truncated to WIDTH bits.
  - Step overflow = operands share a sign bit and `next` has a different sign bit.
  - Mixed-sign operands never overflow.
- Non-final sample (`cnt != N_TERMS-1`):
  - `acc <= step result`
  - `ovf_acc <= ovf_acc | step_ovf`
  - `cnt <= cnt + 1`
- Final sample (`cnt == N_TERMS-1`):
  - `out_sum <= step result`
  - `out_overflow <= ovf_acc | step_ovf`
  - `out_valid <= 1`
  - `acc`, `ovf_acc` and `cnt` return to 0 in the same edge.
- The first sample of every frame adds to 0, so it never overflows.
- `N_TERMS = 1`: every sample is its own frame; `out_sum = in_data`, `out_overflow = 0`.
- `in_valid = 0`: all internal state holds; gaps between samples are allowed anywhere in a frame.
- No explicit FSM beyond the counter. Counter 0 means idle or frame start; any other value means mid-frame.

## Timing
- Reset values: `out_valid = 0`, `out_sum = 0`, `out_overflow = 0`, `acc = 0`, `cnt = 0`, `ovf_acc = 0`.
- Latency: `out_valid` rises in the cycle after the edge that accepts the final sample, and stays high for exactly one cycle.
- Back-to-back frames at full rate: the sample after the final one is accepted as sample 0 of the new frame in the same cycle `out_valid` is high. There are no bubbles.
- `rst` mid-frame: the partial frame is discarded and all state returns to reset values; the next valid sample is sample 0.
- `rst` and `in_valid` in the same cycle: reset wins and the sample is dropped.
- Throughput: one sample per cycle. The combinational path is one WIDTH-bit adder plus the overflow logic.

## Configuration
- Macro: `SIGNED_ACC_SATURATE_EN`.
- Undefined (default): the step result wraps modulo 2^WIDTH. The final sum may be numerically correct even when `out_overflow = 1`, because intermediate wraps are still flagged.
- Defined: on step overflow the step result is clamped.
  - Positive overflow clamps to +(2^(WIDTH-1) − 1).
  - Negative overflow clamps to −2^(WIDTH-1).
  - The clamped value feeds later steps and `out_sum`.
  - `out_overflow` still reports that any clamp occurred.

## Structure
- Package `signed_acc_pkg`:
  - function `smax(width)` returns the largest signed value for `width`.
  - function `smin(width)` returns the smallest signed value for `width`.
  - function `cnt_w(n)` returns the counter width, `max(1, $clog2(n))`.
- Sub-module `signed_add_ovf #(WIDTH)`: combinational adder with inputs `a`, `b` and outputs `sum`, `overflow`.
  - Contains the sign-rule overflow detect and the `SIGNED_ACC_SATURATE_EN` clamp.
  - Instantiated once in the top level; the top level holds only registers and the counter.

## Test plan
All scenarios use `WIDTH=4`, `N_TERMS=4`.
- No overflow: samples 3, 2, 1, 1 → one `out_valid` pulse with `out_sum = 7`, `out_overflow = 0`.
- Intermediate wrap: samples 4, 7, −4, −7.
  - Default build: `out_sum = 0`, `out_overflow = 1` (steps −5, 7, 0).
  - Saturate build: `out_sum = −4`, `out_overflow = 1` (steps 7, 3, −4).
- Negative saturation: samples −8, −1, 0, 0.
  - Default build: `out_sum = 7`, `out_overflow = 1`.
  - Saturate build: `out_sum = −8`, `out_overflow = 1`.
- Back-to-back frames: eight consecutive valid cycles of 1, 1, 1, 1, −1, −1, −1, −1 → two pulses exactly 4 cycles apart.
  - First pulse: sum 4, overflow 0.
  - Second pulse: sum −4, overflow 0.
  - `out_valid` is never high two cycles in a row.
- Gaps: samples 2, 2, 2, 2 with `in_valid` low on alternate cycles → a single pulse 1 cycle after the 4th sample with sum −8 and overflow 1 in the default build (step sequence 2, 4, 6, −8); outputs hold afterwards.
- Reset mid-frame: 7, 7, then `rst` for 1 cycle, then 1, 1, 1, 1 → sum 4 with overflow 0. The earlier overflow does not leak into the new frame, and all outputs read 0 during and right after reset.
